fighting_game: RTL and testbench
================================

// Module: fighting_game
// PURPOSE
//  Two-player turn-based fighting-game core. Each enabled clock cycle it resolves one round from
//  both players' 3-bit action codes: movement on a 1-D arena, punch/kick hits, blocking.
//  Tracks health and reports the winner. Sits between the input decoders and the display logic.
// PARAMETERS
//  INIT_HEALTH  3  health of each player after reset (1..3; health ports are 2 bits)
//  POS_MAX      7  rightmost arena position (positions 0..POS_MAX, 3-bit registers)
//  P1_START     2  player-1 position after reset
//  P2_START     5  player-2 position after reset (must be > P1_START)
//  PUNCH_RANGE  1  max distance (p2-p1) at which a punch lands
//  KICK_RANGE   2  max distance (p2-p1) at which a kick lands
// PORTS
//  clk           in   1  single clock; all state updates on the rising edge
//  resetGame     in   1  synchronous, active-high reset
//  action1       in   3  player-1 action code
//  action2       in   3  player-2 action code
//  actionEnable  in   1  1 = execute one round at this clock edge
//  health1       out  2  player-1 health, registered
//  health2       out  2  player-2 health, registered
//  firstWin      out  1  player 1 has won, registered, sticky
//  secondWin     out  1  player 2 has won, registered, sticky
//  state1        out  3  player-1 state code, registered
//  state2        out  3  player-2 state code, registered
// BEHAVIOUR
//  - Action codes: 000 IDLE, 001 FWD, 010 BACK, 011 PUNCH, 100 KICK, 110 DEFEND.
//  - Codes 101 and 111 are treated as IDLE.
//  - State codes: the same values as the action codes, plus 111 KO.
//  - Reset (resetGame=1 at a clk edge; overrides actionEnable):
//    health1=health2=INIT_HEALTH, firstWin=secondWin=0, state1=state2=000,
//    p1=P1_START, p2=P2_START.
//  - Positions: internal only; invariant 0 <= p1 < p2 <= POS_MAX.
//  - Player 1 faces right, player 2 faces left; d = p2 - p1.
//  - Round: executes at each rising edge with actionEnable=1, no reset, and game not over.
//    All outputs update at that same edge (1-cycle latency).
//    actionEnable=0: all registers hold.
//  - Attacks use the pre-round distance d.
//    PUNCH hits if d <= PUNCH_RANGE; KICK hits if d <= KICK_RANGE.
//    A hit has no effect if the target's action this round is DEFEND.
//    Otherwise the target loses 1 health, saturating at 0.
//    Both players may hit each other in the same round.
//  - Movement (attacking or defending players do not move):
//    FWD: p1+1 / p2-1. BACK: p1-1 / p2+1. BACK is clamped at walls 0 and POS_MAX (no move).
//    If the computed positions would give p1' >= p2', both FWD moves are cancelled.
//    Other moves that round still apply.
//  - stateN = decoded action code of the round (invalid codes -> 000).
//    stateN = 111 if that player's new health is 0.
//  - Win flags are computed from the new health:
//    health2==0 & health1!=0 -> firstWin=1.
//    health1==0 & health2!=0 -> secondWin=1.
//    Both reach 0 in the same round -> firstWin=secondWin=1 (draw).
//  - Game over (either flag set): rounds are ignored, all outputs hold until reset.
//  - Reset mid-game: takes effect at that edge, discarding any round presented in the same cycle.
// TESTING
//  1. Reset -> health1=health2=3, firstWin=secondWin=0, state1=state2=000.
//  2. From reset (d=3): 1 round {001,001} -> d=1, state1=state2=001.
//     Next round {011,000} -> health2=2, state1=011.
//  3. d=3: {100,100} -> both miss, healths unchanged.
//     After one round {001,000} (d=2): {100,110} -> health2 unchanged (blocked), state2=110.
//  4. d=1: 3 rounds {011,000} -> health2 3->2->1->0; firstWin=1, state2=111.
//     Further enabled rounds change nothing.
//  5. d=1, both health=1: {011,011} -> both 0, firstWin=secondWin=1.
//     Then resetGame=1 -> full reset values.
//  6. actionEnable=0 with active actions for 5 cycles -> no output changes.
//     Wall check: {010,010} repeated -> p1 stops at 0, p2 stops at 7.

Source files
------------

// File: rtl/fighting_game.sv
// fighting_game: two-player turn-based fighting core with movement, hits, blocking, health and win tracking
module fighting_game #(
  parameter int INIT_HEALTH = 3,
  parameter int POS_MAX     = 7,
  parameter int P1_START    = 2,
  parameter int P2_START    = 5,
  parameter int PUNCH_RANGE = 1,
  parameter int KICK_RANGE  = 2
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic [2:0] action1,
  input  logic [2:0] action2,
  input  logic       actionEnable,
  output logic [1:0] health1,
  output logic [1:0] health2,
  output logic       firstWin,
  output logic       secondWin,
  output logic [2:0] state1,
  output logic [2:0] state2
);
  typedef enum logic [2:0] {
    IDLE = 3'b000, FWD = 3'b001, BACK = 3'b010, PUNCH = 3'b011,
    KICK = 3'b100, DEFEND = 3'b110, KO = 3'b111
  } act_t;
  localparam logic [2:0] PMAX = 3'(POS_MAX);
  logic [2:0] p1, p2, d, m1, m2, n1, n2;
  logic [1:0] nh1, nh2;
  act_t a1, a2;
  logic hit1, hit2, over;
  always_comb begin
    a1 = (action1 == 3'b101 || action1 == 3'b111) ? IDLE : act_t'(action1);
    a2 = (action2 == 3'b101 || action2 == 3'b111) ? IDLE : act_t'(action2);
    d = p2 - p1;
    hit1 = ((a1 == PUNCH && d <= 3'(PUNCH_RANGE)) || (a1 == KICK && d <= 3'(KICK_RANGE))) && a2 != DEFEND;
    hit2 = ((a2 == PUNCH && d <= 3'(PUNCH_RANGE)) || (a2 == KICK && d <= 3'(KICK_RANGE))) && a1 != DEFEND;
    nh1 = (hit2 && health1 != 2'd0) ? health1 - 2'd1 : health1;
    nh2 = (hit1 && health2 != 2'd0) ? health2 - 2'd1 : health2;
    m1 = a1 == FWD ? p1 + 3'd1 : (a1 == BACK && p1 != 3'd0) ? p1 - 3'd1 : p1;
    m2 = a2 == FWD ? p2 - 3'd1 : (a2 == BACK && p2 != PMAX) ? p2 + 3'd1 : p2;
    // a collision cancels only the forward steps; backward steps still apply
    n1 = (m1 >= m2 && a1 == FWD) ? p1 : m1;
    n2 = (m1 >= m2 && a2 == FWD) ? p2 : m2;
    over = firstWin | secondWin;
  end
  always_ff @(posedge clk) begin
    if (resetGame) begin
      health1   <= 2'(INIT_HEALTH);
      health2   <= 2'(INIT_HEALTH);
      firstWin  <= 1'b0;
      secondWin <= 1'b0;
      state1    <= IDLE;
      state2    <= IDLE;
      p1        <= 3'(P1_START);
      p2        <= 3'(P2_START);
    end else if (actionEnable && !over) begin
      health1   <= nh1;
      health2   <= nh2;
      firstWin  <= nh2 == 2'd0;
      secondWin <= nh1 == 2'd0;
      state1    <= nh1 == 2'd0 ? KO : a1;
      state2    <= nh2 == 2'd0 ? KO : a2;
      p1        <= n1;
      p2        <= n2;
    end
  end
endmodule

// File: tb/tb_fighting_game.sv
// tb_fighting_game: table-driven round vectors plus a game-over hold sequence
module tb_fighting_game;
  logic clk = 0, resetGame = 0, actionEnable = 0;
  logic [2:0] action1 = 0, action2 = 0;
  logic [1:0] health1, health2;
  logic firstWin, secondWin;
  logic [2:0] state1, state2;
  int applied = 0, miscompares = 0;

  fighting_game dut (
    .clk(clk), .resetGame(resetGame), .action1(action1), .action2(action2),
    .actionEnable(actionEnable), .health1(health1), .health2(health2),
    .firstWin(firstWin), .secondWin(secondWin), .state1(state1), .state2(state2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en;
    logic [2:0] a1, a2;
    logic [1:0] h1, h2;
    logic fw, sw;
    logic [2:0] s1, s2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic en, logic [2:0] a1, logic [2:0] a2,
                             logic [1:0] h1, logic [1:0] h2, logic fw, logic sw,
                             logic [2:0] s1, logic [2:0] s2);
    vec_t r;
    r.rst = rst; r.en = en; r.a1 = a1; r.a2 = a2;
    r.h1 = h1; r.h2 = h2; r.fw = fw; r.sw = sw; r.s1 = s1; r.s2 = s2;
    return r;
  endfunction

  task automatic apply(input string name, input vec_t x);
    logic [11:0] got, exp;
    @(negedge clk);
    resetGame = x.rst; actionEnable = x.en; action1 = x.a1; action2 = x.a2;
    @(posedge clk);
    #1;
    got = {health1, health2, firstWin, secondWin, state1, state2};
    exp = {x.h1, x.h2, x.fw, x.sw, x.s1, x.s2};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got h1=%0d h2=%0d fw=%b sw=%b s1=%b s2=%b, required h1=%0d h2=%0d fw=%b sw=%b s1=%b s2=%b",
               name, health1, health2, firstWin, secondWin, state1, state2,
               x.h1, x.h2, x.fw, x.sw, x.s1, x.s2);
    end
  endtask

  initial begin
    // reset, approach, punch
    tbl.push_back(v(1,0,0,0, 3,3,0,0,0,0));
    tbl.push_back(v(0,1,1,1, 3,3,0,0,1,1));
    tbl.push_back(v(0,1,3,0, 3,2,0,0,3,0));
    // out-of-range kicks, block, in-range kick, invalid codes
    tbl.push_back(v(1,0,0,0, 3,3,0,0,0,0));
    tbl.push_back(v(0,1,4,4, 3,3,0,0,4,4));
    tbl.push_back(v(0,1,1,0, 3,3,0,0,1,0));
    tbl.push_back(v(0,1,4,6, 3,3,0,0,4,6));
    tbl.push_back(v(0,1,4,0, 3,2,0,0,4,0));
    tbl.push_back(v(0,1,5,7, 3,2,0,0,0,0));
    // knockout of player 2, then game over holds
    tbl.push_back(v(0,1,1,0, 3,2,0,0,1,0));
    tbl.push_back(v(0,1,3,0, 3,1,0,0,3,0));
    tbl.push_back(v(0,1,3,0, 3,0,1,0,3,7));
    tbl.push_back(v(0,1,0,3, 3,0,1,0,3,7));
    tbl.push_back(v(0,1,1,1, 3,0,1,0,3,7));
    // reset overrides an enabled round; forward collisions cancelled
    tbl.push_back(v(1,1,3,3, 3,3,0,0,0,0));
    tbl.push_back(v(0,1,1,0, 3,3,0,0,1,0));
    tbl.push_back(v(0,1,1,0, 3,3,0,0,1,0));
    tbl.push_back(v(0,1,1,1, 3,3,0,0,1,1));
    tbl.push_back(v(0,1,1,0, 3,3,0,0,1,0));
    tbl.push_back(v(0,1,2,0, 3,3,0,0,2,0));
    tbl.push_back(v(0,1,3,0, 3,3,0,0,3,0));
    tbl.push_back(v(0,1,1,0, 3,3,0,0,1,0));
    // mutual hits, defend, disabled round, draw
    tbl.push_back(v(0,1,3,3, 2,2,0,0,3,3));
    tbl.push_back(v(0,1,3,3, 1,1,0,0,3,3));
    tbl.push_back(v(0,1,6,3, 1,1,0,0,6,3));
    tbl.push_back(v(0,0,3,3, 1,1,0,0,6,3));
    tbl.push_back(v(0,1,3,3, 0,0,1,1,7,7));
    tbl.push_back(v(1,1,3,3, 3,3,0,0,0,0));
    // disabled cycles hold everything
    for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,3'(i+1),3'(4-i), 3,3,0,0,0,0));
    // walls: p1 stops at 0, p2 at 7
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,2,2, 3,3,0,0,2,2));
    // from 0/7 three forward steps leave d=1
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,1, 3,3,0,0,1,1));
    tbl.push_back(v(0,1,0,3, 2,3,0,0,0,3));
    tbl.push_back(v(0,1,0,4, 1,3,0,0,0,4));
    tbl.push_back(v(0,1,0,3, 0,3,0,1,7,3));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // second-player win must hold against any further enabled rounds
    for (int i = 0; i < 6; i++)
      apply($sformatf("hold%0d", i), v(0,1,3'($urandom_range(0,7)),3'($urandom_range(0,7)), 0,3,0,1,7,3));
    apply("final_reset", v(1,1,4,4, 3,3,0,0,0,0));
    apply("post_reset_round", v(0,1,4,4, 3,3,0,0,4,4));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
